pipe_stage_fifo: RTL and testbench

Parametrised successor to the single-entry incrementing pipeline stage. Accepts words from the previous stage over the DIR/ack_prev handshake and transforms each by a constant add, wrapping or saturating. Buffers up to DEPTH results and offers them to the next stage over the DOR/ack_from_next handshake. Sits between pipeline stages in the examples/pipeline chain, so that a stalled downstream stage no longer blocks the upstream stage immediately.

---
 rtl/pipe_stage_fifo.sv | 114 +++++++++++
 tb/tb_pipe_stage_fifo.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_fifo.sv
// Incrementing pipeline stage with a DEPTH-entry result buffer between the
// DIR/ack_prev upstream handshake and the DOR/ack_from_next downstream handshake.
module pipe_stage_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 4,
    parameter  int INC   = 1,
    parameter  int SAT   = 0,
    localparam int LVL_W = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             DIR,
    input  logic [WIDTH-1:0] data_in,
    output logic             ack_prev,
    output logic             DOR,
    output logic [WIDTH-1:0] data_out,
    input  logic             ack_from_next,
    output logic [LVL_W-1:0] level
);

    localparam int               PTR_W    = $clog2(DEPTH);
    localparam logic [WIDTH-1:0] INC_W    = WIDTH'(INC);
    localparam logic [LVL_W-1:0] FULL_LVL = LVL_W'(DEPTH);

    typedef enum logic {ACCEPT, HOLDOFF} state_t;

    state_t             state_reg, state_next;
    logic               ack_reg, ack_next;
    logic               dor_reg;
    logic [WIDTH-1:0]   data_out_reg;
    logic [PTR_W-1:0]   wr_ptr_reg, rd_ptr_reg, rd_ptr_next;
    logic [LVL_W-1:0]   count_reg, count_next;
    logic [WIDTH-1:0]   mem [DEPTH];

    logic               push, pop;
    logic [WIDTH:0]     sum_ext;
    logic               sat_hit;
    logic [WIDTH-1:0]   f_val;
    logic [WIDTH-1:0]   head_next;

    // One extra carry bit tells us whether the add overflowed.
    assign sum_ext = {1'b0, data_in} + {1'b0, INC_W};
    assign sat_hit = (SAT != 0) && sum_ext[WIDTH];
    assign f_val   = sat_hit ? '1 : sum_ext[WIDTH-1:0];

    always_comb begin
        state_next = state_reg;
        ack_next   = 1'b0;
        push       = 1'b0;
        case (state_reg)
            ACCEPT: begin
                if (DIR && (count_reg != FULL_LVL)) begin
                    push       = 1'b1;
                    ack_next   = 1'b1;
                    state_next = HOLDOFF;
                end
            end
            HOLDOFF: state_next = ACCEPT;
            default: state_next = ACCEPT;
        endcase
    end

    assign pop         = ack_from_next && (count_reg != '0);
    assign rd_ptr_next = pop ? rd_ptr_reg + PTR_W'(1) : rd_ptr_reg;

    always_comb begin
        count_next = count_reg;
        case ({push, pop})
            2'b10:   count_next = count_reg + LVL_W'(1);
            2'b01:   count_next = count_reg - LVL_W'(1);
            default: count_next = count_reg;
        endcase
    end

    // Forward the word being written when it lands in the next head slot,
    // so an empty buffer shows the new result right after the accept edge.
    assign head_next = (push && (wr_ptr_reg == rd_ptr_next)) ? f_val : mem[rd_ptr_next];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr_reg] <= f_val;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg    <= ACCEPT;
            ack_reg      <= 1'b0;
            dor_reg      <= 1'b0;
            data_out_reg <= '0;
            wr_ptr_reg   <= '0;
            rd_ptr_reg   <= '0;
            count_reg    <= '0;
        end else begin
            state_reg  <= state_next;
            ack_reg    <= ack_next;
            rd_ptr_reg <= rd_ptr_next;
            count_reg  <= count_next;
            dor_reg    <= (count_next != '0);
            if (push) begin
                wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            end
            if (count_next != '0) begin
                data_out_reg <= head_next;
            end
        end
    end

    assign ack_prev = ack_reg;
    assign DOR      = dor_reg;
    assign data_out = data_out_reg;
    assign level    = count_reg;

endmodule

// File: tb/tb_pipe_stage_fifo.sv
// Randomised and directed bench for pipe_stage_fifo against a queue-based
// behavioural model of the accept/hold-off/FIFO rules.
module tb_pipe_stage_fifo;

    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int LVL_W = $clog2(DEPTH) + 1;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             dir = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             ack;
    logic             dor;
    logic [WIDTH-1:0] dout;
    logic             ackn = 1'b0;
    logic [LVL_W-1:0] lvl;

    logic             dir2 = 1'b0;
    logic [WIDTH-1:0] din2 = '0;
    logic             ack2;
    logic             dor2;
    logic [WIDTH-1:0] dout2;
    logic             ackn2 = 1'b0;
    logic [LVL_W-1:0] lvl2;

    int total = 0;
    int bad   = 0;

    int  mq[$];
    bit  holdoff = 1'b0;
    int  up_q[$];
    int  got_log[$];
    int  ack_mode = 0;
    int  ack_seen = 0;
    int  consec   = 0;
    int  max_lvl  = 0;
    bit  prev_ack = 1'b0;

    always #5 clk = ~clk;

    pipe_stage_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INC(1), .SAT(0)) dut (
        .clk(clk), .reset(rst), .DIR(dir), .data_in(din), .ack_prev(ack),
        .DOR(dor), .data_out(dout), .ack_from_next(ackn), .level(lvl)
    );

    pipe_stage_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .INC(3), .SAT(1)) dut_sat (
        .clk(clk), .reset(rst), .DIR(dir2), .data_in(din2), .ack_prev(ack2),
        .DOR(dor2), .data_out(dout2), .ack_from_next(ackn2), .level(lvl2)
    );

    function automatic int f(int x, int inc, int sat);
        int s = x + inc;
        if (sat != 0) return (s > 255) ? 255 : s;
        return s % 256;
    endfunction

    task automatic check(input string tag, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    task automatic refresh_up();
        dir = (up_q.size() > 0);
        din = (up_q.size() > 0) ? WIDTH'(up_q[0]) : '0;
    endtask

    task automatic load(input int v);
        up_q.push_back(v);
        refresh_up();
    endtask

    // One clock: model the edge from the inputs as driven, then compare at +1.
    task automatic tick();
        bit acc;
        bit pp;
        if (ackn && dor) got_log.push_back(int'(dout));
        acc = !rst && dir && !holdoff && (mq.size() < DEPTH);
        pp  = !rst && ackn && (mq.size() > 0);
        @(posedge clk);
        if (rst) begin
            mq.delete();
            holdoff = 1'b0;
        end else begin
            if (pp) void'(mq.pop_front());
            if (acc) mq.push_back(f(int'(din), 1, 0));
            holdoff = acc;
        end
        #1;
        check("ack_prev", int'(ack), int'(acc));
        check("dor", int'(dor), int'(mq.size() != 0));
        check("level", int'(lvl), mq.size());
        if (mq.size() != 0) check("data_out", int'(dout), mq[0]);
        if (ack) ack_seen++;
        if (ack && prev_ack) consec++;
        prev_ack = ack;
        if (int'(lvl) > max_lvl) max_lvl = int'(lvl);
        if (acc) void'(up_q.pop_front());
        refresh_up();
        case (ack_mode)
            1:       ackn = 1'b1;
            2:       ackn = 1'($urandom_range(0, 1));
            default: ;
        endcase
    endtask

    task automatic drain(input int n, output int got_n);
        int budget = 200;
        got_log.delete();
        ack_mode = 1;
        ackn = 1'b1;
        while (got_log.size() < n && budget > 0) begin
            tick();
            budget--;
        end
        ack_mode = 0;
        ackn = 1'b0;
        tick();
        got_n = got_log.size();
    endtask

    initial begin
        int n;
        int a0;
        int budget;

        // Reset and idle
        repeat (3) tick();
        rst = 1'b0;
        repeat (10) begin
            tick();
            check("idle_dout", int'(dout), 0);
        end

        // Single word round trip
        load(5);
        tick();
        check("single_ack", int'(ack), 1);
        check("single_dout", int'(dout), 6);
        check("single_level", int'(lvl), 1);
        tick();
        ackn = 1'b1;
        tick();
        ackn = 1'b0;
        check("single_pop_dor", int'(dor), 0);
        check("single_pop_level", int'(lvl), 0);

        // Fill and stall
        a0 = ack_seen;
        for (int v = 10; v <= 14; v++) load(v);
        repeat (12) tick();
        check("fill_acks", ack_seen - a0, 4);
        check("fill_level", int'(lvl), 4);
        check("fill_pending", up_q.size(), 1);
        check("fill_head", int'(dout), 11);
        ackn = 1'b1;
        tick();
        ackn = 1'b0;
        check("pop_head", int'(dout), 12);
        tick();
        check("refill_ack", int'(ack), 1);
        check("refill_level", int'(lvl), 4);
        drain(4, n);
        check("drain_count", n, 4);
        for (int i = 0; i < 4 && i < n; i++) check("drain_order", got_log[i], 12 + i);

        // Modulo wrap
        load(255);
        tick();
        check("wrap_dout", int'(dout), 0);
        drain(1, n);

        // Saturating instance
        dir2 = 1'b1; din2 = 8'd254;
        tick();
        check("sat_ack", int'(ack2), 1);
        check("sat_dout_254", int'(dout2), f(254, 3, 1));
        dir2 = 1'b0; ackn2 = 1'b1;
        tick();
        check("sat_pop_dor", int'(dor2), 0);
        ackn2 = 1'b0;
        tick();
        dir2 = 1'b1; din2 = 8'd100;
        tick();
        check("sat_dout_100", int'(dout2), f(100, 3, 1));
        dir2 = 1'b0; ackn2 = 1'b1;
        tick();
        check("sat_pop_level", int'(lvl2), 0);
        ackn2 = 1'b0;
        tick();

        // Concurrent traffic with random downstream acks
        got_log.delete();
        consec = 0;
        max_lvl = 0;
        for (int v = 0; v < 32; v++) up_q.push_back(v);
        refresh_up();
        ack_mode = 2;
        budget = 2000;
        while (got_log.size() < 32 && budget > 0) begin
            tick();
            budget--;
        end
        ack_mode = 0;
        ackn = 1'b0;
        tick();
        check("stream_count", got_log.size(), 32);
        for (int i = 0; i < 32 && i < got_log.size(); i++) check("stream_order", got_log[i], i + 1);
        check("stream_max_level_ok", int'(max_lvl <= DEPTH), 1);
        check("stream_no_b2b_ack", consec, 0);

        // Spurious acks on an empty buffer
        ack_mode = 1;
        ackn = 1'b1;
        repeat (5) begin
            tick();
            check("spur_level", int'(lvl), 0);
        end
        ack_mode = 0;
        ackn = 1'b0;
        tick();
        load(77);
        tick();
        check("spur_rt_dout", int'(dout), 78);
        drain(1, n);
        check("spur_rt_count", n, 1);
        if (n > 0) check("spur_rt_val", got_log[0], 78);

        // Asynchronous reset mid-transfer
        load(1);
        load(2);
        repeat (4) tick();
        check("pre_reset_level", int'(lvl), 2);
        up_q.delete();
        load(9);
        #3;
        rst = 1'b1;
        mq.delete();
        holdoff = 1'b0;
        #1;
        check("async_rst_dor", int'(dor), 0);
        check("async_rst_level", int'(lvl), 0);
        check("async_rst_dout", int'(dout), 0);
        check("async_rst_ack", int'(ack), 0);
        repeat (2) tick();
        rst = 1'b0;
        tick();
        check("post_reset_ack", int'(ack), 1);
        check("post_reset_dout", int'(dout), 10);
        drain(1, n);
        check("post_reset_count", n, 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
